// File: rtl/string_detector_ctrl_if.sv
// string_detector_ctrl_if -- bundle of the requester, serial-data and result
// signals of string_detector_ctrl.
//   slave  : the controller side (requests/patterns/bits in, grants/result out)
//   master : the requesters plus the result consumer
// Signals:
//   req[1:0]          frame request per requester (level)
//   pattern0/1[3:0]   4-bit search pattern per requester
//   bit_in0/1         serial data per requester
//   bit_vld0/1        serial data valid per requester
//   bit_rdy[1:0]      bit accepted this cycle (granted requester only)
//   gnt[1:0]          one-hot grant, held for the whole frame
//   res_vld/res_rdy   result handshake
//   res_id            requester index of the result
//   res_count[4:0]    match count of the finished frame
//   busy              controller not idle
interface string_detector_ctrl_if;
  logic [1:0] req;
  logic [3:0] pattern0;
  logic [3:0] pattern1;
  logic       bit_in0;
  logic       bit_in1;
  logic       bit_vld0;
  logic       bit_vld1;
  logic [1:0] bit_rdy;
  logic [1:0] gnt;
  logic       res_vld;
  logic       res_rdy;
  logic       res_id;
  logic [4:0] res_count;
  logic       busy;

  modport slave (
    input  req, pattern0, pattern1, bit_in0, bit_in1, bit_vld0, bit_vld1, res_rdy,
    output bit_rdy, gnt, res_vld, res_id, res_count, busy
  );

  modport master (
    output req, pattern0, pattern1, bit_in0, bit_in1, bit_vld0, bit_vld1, res_rdy,
    input  bit_rdy, gnt, res_vld, res_id, res_count, busy
  );
endinterface

// File: rtl/string_detector_ctrl.sv
// string_detector_ctrl -- two-requester round-robin controller that streams
// FRAME_LEN serial bits from the granted requester through a 4-bit pattern
// detector, idles GAP_LEN flush cycles, then reports the match count.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : string_detector_ctrl_if.slave (request, serial data, result)
// Parameters:
//   FRAME_LEN : serial bits per frame (4..31)
//   GAP_LEN   : flush cycles after each frame (1..15)
// Configuration macro:
//   STRDET_OVERLAP_EN : when defined, overlapping matches are counted; when
//                       undefined a match empties the window fill count so the
//                       next match needs 4 fresh bits.
module string_detector_ctrl #(
  parameter int FRAME_LEN = 20,
  parameter int GAP_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  string_detector_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP, REPORT} state_e;

  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);
  localparam logic [3:0] LAST_GAP = 4'(GAP_LEN - 1);

  state_e     state_q, state_d;
  logic [1:0] gnt_q,   gnt_d;
  logic       id_q,    id_d;
  logic       last_q,  last_d;   // requester granted most recently
  logic [3:0] pat_q,   pat_d;
  logic [3:0] win_q,   win_d;
  logic [2:0] fill_q,  fill_d;   // bits in window since last clear, saturates at 4
  logic [4:0] bcnt_q,  bcnt_d;
  logic [4:0] mcnt_q,  mcnt_d;
  logic [3:0] gap_q,   gap_d;

  logic       cur_bit, cur_vld, hit, nxt_id;
  logic [3:0] win_sh;
  logic [2:0] fill_inc;

  assign cur_bit  = id_q ? bus.bit_in1  : bus.bit_in0;
  assign cur_vld  = id_q ? bus.bit_vld1 : bus.bit_vld0;
  assign win_sh   = {win_q[2:0], cur_bit};
  assign fill_inc = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
  // Match is judged on the window as it will look after this bit shifts in.
  assign hit      = (fill_inc == 3'd4) && (win_sh == pat_q);
  // Both requesting: hand over to whoever did not go last.
  assign nxt_id   = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    pat_d   = pat_q;
    win_d   = win_q;
    fill_d  = fill_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          id_d    = nxt_id;
          last_d  = nxt_id;
          gnt_d   = nxt_id ? 2'b10 : 2'b01;
          pat_d   = nxt_id ? bus.pattern1 : bus.pattern0;
          win_d   = '0;
          fill_d  = '0;
          bcnt_d  = '0;
          mcnt_d  = '0;
          gap_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (cur_vld) begin
          win_d  = win_sh;
          bcnt_d = bcnt_q + 5'd1;
          fill_d = fill_inc;
          if (hit) begin
            if (mcnt_q != 5'd31) mcnt_d = mcnt_q + 5'd1;
`ifdef STRDET_OVERLAP_EN
            fill_d = fill_inc;
`else
            fill_d = '0;
`endif
          end
          if (bcnt_q == LAST_BIT) begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == LAST_GAP) state_d = REPORT;
      end
      REPORT: begin
        if (bus.res_rdy) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;   // so requester 0 wins the first contested grant
      pat_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bit_rdy   = (state_q == STREAM) ? gnt_q : 2'b00;
  assign bus.res_vld   = (state_q == REPORT);
  assign bus.res_id    = id_q;
  assign bus.res_count = mcnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_string_detector_ctrl.sv
// tb_string_detector_ctrl -- directed bench for string_detector_ctrl with
// FRAME_LEN=20, GAP_LEN=4. Latency is counted with the cycle in which gnt is
// first seen high as cycle 1; res_vld must first be seen in cycle
// FRAME_LEN+GAP_LEN+1 for a continuous stream.
module tb_string_detector_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  string_detector_ctrl_if bus();

  string_detector_ctrl #(.FRAME_LEN(20), .GAP_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef STRDET_OVERLAP_EN
  localparam int E_ALT  = 9;
  localparam int E_ONES = 17;
`else
  localparam int E_ALT  = 5;
  localparam int E_ONES = 5;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt),       0);
    chk({tag, "_rdy"},   32'(bus.bit_rdy),   0);
    chk({tag, "_vld"},   32'(bus.res_vld),   0);
    chk({tag, "_busy"},  32'(bus.busy),      0);
    chk({tag, "_id"},    32'(bus.res_id),    0);
    chk({tag, "_count"}, 32'(bus.res_count), 0);
  endtask

  // Wait for a grant, then feed bits[19:0] MSB first to requester id.
  // nbits==0 runs until res_vld; otherwise stops after nbits accepted bits.
  task automatic frame(input int id, input logic [19:0] bits, input bit tog,
                       input int nbits, input bit drop, input bit chpat,
                       output int w, output int lat);
    int idx; bit ph; bit acc; bit bad; logic vld; logic b;
    w = 0;
    do begin @(posedge clk); #1; w++; end while (bus.gnt == 2'b00 && w < 20);
    chk("gnt_onehot", 32'(bus.gnt), (id == 1) ? 32'd2 : 32'd1);
    if (drop)  bus.req = 2'b00;
    if (chpat) begin bus.pattern0 = 4'b0000; bus.pattern1 = 4'b0000; end
    idx = 0; ph = 1'b0; lat = 1; bad = 1'b0;
    while (!bus.res_vld && lat < 200 && (nbits == 0 || idx < nbits)) begin
      @(negedge clk);
      vld = (idx < 20) && (!tog || ph);
      b   = (idx < 20) ? bits[19 - idx] : 1'b0;
      if (id == 0) begin
        bus.bit_in0 = b; bus.bit_vld0 = vld; bus.bit_in1 = 1'b0; bus.bit_vld1 = 1'b1;
      end else begin
        bus.bit_in1 = b; bus.bit_vld1 = vld; bus.bit_in0 = 1'b0; bus.bit_vld0 = 1'b1;
      end
      acc = bus.bit_rdy[id] && vld;
      if (bus.bit_rdy[1 - id]) bad = 1'b1;
      @(posedge clk);
      if (acc) idx++;
      #1;
      lat++;
      ph = ~ph;
    end
    bus.bit_vld0 = 1'b0; bus.bit_vld1 = 1'b0;
    chk("rdy_other_low", 32'(bad), 0);
  endtask

  task automatic check_result(input string tag, input int id, input int cnt, input int lat_exp, input int lat);
    chk({tag, "_vld"},   32'(bus.res_vld),   1);
    chk({tag, "_id"},    32'(bus.res_id),    32'(id));
    chk({tag, "_count"}, 32'(bus.res_count), 32'(cnt));
    chk({tag, "_lat"},   32'(lat),           32'(lat_exp));
  endtask

  // res_rdy is high: handshake on the next edge, then one idle cycle.
  task automatic finish_frame(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    chk({tag, "_idle_gnt"},  32'(bus.gnt),  0);
  endtask

  initial begin
    int w, lat; bit stable;
    bus.req = 2'b01; bus.pattern0 = 4'b1010; bus.pattern1 = 4'b0000;
    bus.bit_in0 = 1'b0; bus.bit_in1 = 1'b0; bus.bit_vld0 = 1'b0; bus.bit_vld1 = 1'b0;
    bus.res_rdy = 1'b1;

    // Reset state, then first grant on the first edge after release.
    #3;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // 1010 stream, continuous; req dropped mid-frame must not abort.
    frame(0, 20'hAAAAA, 1'b0, 0, 1'b1, 1'b0, w, lat);
    chk("first_gnt_wait", 32'(w), 1);
    check_result("alt", 0, E_ALT, 25, lat);
    finish_frame("alt");

    // Reset restores requester-0 priority even though 0 went last.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); bus.req = 2'b11; bus.pattern0 = 4'b1111; bus.pattern1 = 4'b1111;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame(k % 2, 20'hFFFFF, 1'b0, 0, 1'b0, 1'b0, w, lat);
      check_result("rr", k % 2, E_ONES, 25, lat);
      finish_frame("rr");
    end
    bus.req = 2'b00;

    // bit_vld toggling: same count, doubled stream time.
    @(negedge clk); bus.req = 2'b01; bus.pattern0 = 4'b1010;
    frame(0, 20'hAAAAA, 1'b1, 0, 1'b1, 1'b0, w, lat);
    check_result("tog", 0, E_ALT, 45, lat);
    finish_frame("tog");

    // Result held with res_rdy low for 10 cycles.
    @(negedge clk); bus.req = 2'b10; bus.pattern1 = 4'b0110; bus.res_rdy = 1'b0;
    frame(1, 20'h66666, 1'b0, 0, 1'b1, 1'b0, w, lat);
    check_result("hold", 1, 5, 25, lat);
    bus.req = 2'b01;   // pending request must wait for the handshake
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.res_vld !== 1'b1 || bus.res_count !== 5'd5 || bus.res_id !== 1'b1 || bus.gnt !== 2'b10)
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    @(negedge clk); bus.res_rdy = 1'b1; bus.req = 2'b00;
    finish_frame("hold");

    // Reset after 7 accepted bits discards the frame.
    @(negedge clk); bus.req = 2'b01; bus.pattern0 = 4'b1111;
    frame(0, 20'hFFFFF, 1'b0, 7, 1'b0, 1'b0, w, lat);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2; rst_n = 1'b0; #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    chk("rst_no_vld", 32'(bus.res_vld), 0);
    @(negedge clk); rst_n = 1'b1;
    frame(0, 20'hFFFFF, 1'b0, 0, 1'b1, 1'b0, w, lat);
    check_result("post_rst", 0, E_ONES, 25, lat);
    finish_frame("post_rst");

    // Pattern change after grant is ignored.
    @(negedge clk); bus.req = 2'b01; bus.pattern0 = 4'b1010;
    frame(0, 20'h00000, 1'b0, 0, 1'b1, 1'b1, w, lat);
    check_result("patchg", 0, 0, 25, lat);
    finish_frame("patchg");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/string_detector_ctrl.md
STRING_DETECTOR_CTRL -- requirements
Module: string_detector_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 20, number of serial bits per frame (legal 4..31).
REQ-002 SHALL have parameter GAP_LEN, default 4, idle flush cycles after each frame (legal 1..15).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req[1:0]  input  2  frame request per requester; level, held until granted.
REQ-006 pattern0, pattern1  input  4 each  search pattern of requester 0/1, sampled at grant.
REQ-007 bit_in0, bit_in1  input  1 each  serial data of requester 0/1.
REQ-008 bit_vld0, bit_vld1  input  1 each  serial bit valid of requester 0/1.
REQ-009 bit_rdy[1:0]  output  2  bit accepted this cycle; only granted requester's bit may be high.
REQ-010 gnt[1:0]  output  2  one-hot grant, held for whole frame including gap and report.
REQ-011 res_vld  output  1  result valid.
REQ-012 res_rdy  input  1  result consumer ready.
REQ-013 res_id  output  1  requester index of result.
REQ-014 res_count  output  5  match count of finished frame.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement states IDLE, STREAM, GAP, REPORT.
REQ-017 IDLE: if any req bit high, SHALL grant one requester, latch its pattern, clear window, bit counter and match count, enter STREAM next cycle.
REQ-018 Arbitration SHALL be round-robin: with both requesting, grant goes to requester not granted last; after reset requester 0 has priority.
REQ-019 STREAM: bit_rdy of granted requester SHALL be high; a bit is accepted when its bit_vld is also high; invalid cycles stall with no state change.
REQ-020 On each accepted bit SHALL shift window left (new bit to LSB) and increment bit counter.
REQ-021 Match SHALL be evaluated on the post-shift window, only once at least 4 bits accepted since last window clear; match increments count, saturating at 31.
REQ-022 After the FRAME_LEN-th accepted bit SHALL enter GAP; bit_rdy low from that cycle.
REQ-023 GAP SHALL last exactly GAP_LEN cycles, no bits accepted, then REPORT.
REQ-024 REPORT: res_vld high with res_id, res_count stable until res_vld and res_rdy both high; then gnt clears and state returns to IDLE in the same edge.
REQ-025 New grant SHALL NOT occur earlier than the cycle after the result handshake (minimum one IDLE cycle between frames).
REQ-026 Requester dropping req mid-frame SHALL NOT abort the frame; frame completes only via bits.
REQ-027 Pattern input changes after grant SHALL have no effect on current frame.
REQ-028 Frame latency with continuous valid: grant edge to res_vld = FRAME_LEN + GAP_LEN + 1 cycles.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; gnt, bit_rdy, res_vld, busy = 0; res_id = 0; res_count = 0; window, counters cleared; round-robin pointer favours requester 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no result produced.
REQ-031 First grant SHALL occur on first rising edge after rst_n deasserts with req high.

Configuration
REQ-032 Macro STRDET_OVERLAP_EN SHALL select match mode.
REQ-033 With STRDET_OVERLAP_EN defined, overlapping matches count (pattern 1010 on stream 101010 = 2).
REQ-034 Without it, each match clears window fill count, requiring 4 fresh bits before next match (101010 with 1010 = 1).

Verification
REQ-035 Reset, req=01, pattern0=1010, bits 1010_1010_1010_1010_1010 continuous, res_rdy=1 -> res_count=9 overlap / 5 non-overlap, res_id=0, res_vld 25 cycles after grant.
REQ-036 req=11 held, both patterns 1111, all-ones streams -> grants alternate 0,1,0,1; counts 17 (overlap) / 5 (non-overlap).
REQ-037 bit_vld0 toggled every other cycle -> same count as continuous, res_vld 45 cycles after grant.
REQ-038 res_rdy held low 10 cycles in REPORT -> res_vld, res_count, res_id stable, no new grant until handshake.
REQ-039 rst_n pulsed low after 7 accepted bits -> outputs zero asynchronously, no res_vld; next frame counts from 0.
REQ-040 pattern0 changed after grant, stream never contains the original pattern -> res_count=0.
